// File: rtl/gol_pkg.sv
// ============================================================================
// Module   : gol_pkg
// Purpose  : Shared FSM state type and default board geometry for the
//            Game-of-Life generation buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gol_pkg;

   localparam int GOL_WIDTH = 8;
   localparam int GOL_ROWS  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      SWAP = 2'd2
   } gol_state_t;

endpackage

`default_nettype wire

// File: rtl/gol_row_bank.sv
// ============================================================================
// Module   : gol_row_bank
// Purpose  : ROWS x WIDTH board storage, one synchronous write port, every
//            row visible combinationally, asynchronously cleared to zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gol_row_bank
   import gol_pkg::*;
#(
   parameter int WIDTH   = GOL_WIDTH,
   parameter int ROWS    = GOL_ROWS,
   parameter int ROWBITS = $clog2(ROWS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic [ROWBITS-1:0]           waddr,
   input  logic [WIDTH-1:0]             wdata,
   output logic [ROWS-1:0][WIDTH-1:0]   rows
);

   // Address range is qualified by the caller; only in-range rows arrive here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rows <= '0;
      end else if (we) begin
         rows[waddr] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gol_gen_buffer.sv
// ============================================================================
// Module   : gol_gen_buffer
// Purpose  : Double-buffered Game-of-Life board: scans the current bank row
//            by row as an N/C/S window, collects next rows, swaps at the end.
//            Optional macro GOL_WRAP_EN selects toroidal row neighbours.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gol_gen_buffer
   import gol_pkg::*;
#(
   parameter int WIDTH   = GOL_WIDTH,
   parameter int ROWS    = GOL_ROWS,
   parameter int ROWBITS = $clog2(ROWS),
   parameter int GENBITS = 16
) (
   input  logic                 ph2,
   input  logic                 reset,
   input  logic                 step,
   input  logic                 run,
   input  logic                 load_en,
   input  logic [ROWBITS-1:0]   load_addr,
   input  logic [WIDTH-1:0]     load_data,
   input  logic [ROWBITS-1:0]   rd_addr,
   output logic [WIDTH-1:0]     rd_data,
   output logic                 win_valid,
   output logic [ROWBITS-1:0]   win_row,
   output logic [WIDTH-1:0]     win_n,
   output logic [WIDTH-1:0]     win_c,
   output logic [WIDTH-1:0]     win_s,
   input  logic                 nxt_valid,
   input  logic [WIDTH-1:0]     nxt_data,
   output logic                 busy,
   output logic                 gen_done,
   output logic [GENBITS-1:0]   gen_count,
   output logic                 extinct
);

`ifdef GOL_WRAP_EN
   localparam logic ROW_WRAP = 1'b1;
`else
   localparam logic ROW_WRAP = 1'b0;
`endif

   localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(ROWS - 1);
   localparam logic [ROWBITS:0]   ROWS_EXT = (ROWBITS + 1)'(ROWS);

   gol_state_t                      r_state;
   logic                            r_sel;
   logic [ROWBITS-1:0]              r_row;
   logic [GENBITS-1:0]              r_gen;
   logic                            r_busy;
   logic                            r_valid;
   logic                            r_done;

   logic                            w_load_wr;
   logic                            w_nxt_wr;
   logic [ROWBITS-1:0]              w_waddr;
   logic [WIDTH-1:0]                w_wdata;
   logic [1:0]                      w_bank_we;
   logic [1:0][ROWS-1:0][WIDTH-1:0] w_bank_rows;
   logic [ROWS-1:0][WIDTH-1:0]      w_cur;

   // Host loads only ever target the current bank, scan results only the
   // other one, and the two never coexist in one state, so a shared port works.
   assign w_load_wr = (r_state == IDLE) && load_en && ({1'b0, load_addr} < ROWS_EXT);
   assign w_nxt_wr  = (r_state == SCAN) && nxt_valid;
   assign w_waddr   = w_load_wr ? load_addr : r_row;
   assign w_wdata   = w_load_wr ? load_data : nxt_data;

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         assign w_bank_we[b] = (w_load_wr && (r_sel == 1'(b))) ||
                               (w_nxt_wr  && (r_sel != 1'(b)));

         gol_row_bank #(
            .WIDTH   (WIDTH),
            .ROWS    (ROWS),
            .ROWBITS (ROWBITS)
         ) u_bank (
            .clk     (ph2),
            .reset   (reset),
            .we      (w_bank_we[b]),
            .waddr   (w_waddr),
            .wdata   (w_wdata),
            .rows    (w_bank_rows[b])
         );
      end
   endgenerate

   assign w_cur   = w_bank_rows[r_sel];
   assign rd_data = ({1'b0, rd_addr} < ROWS_EXT) ? w_cur[rd_addr] : '0;
   assign extinct = ~|w_cur;

   always_comb begin
      win_c = w_cur[r_row];
      win_n = '0;
      win_s = '0;
      if (r_row != '0) begin
         win_n = w_cur[r_row - ROWBITS'(1)];
      end else if (ROW_WRAP) begin
         win_n = w_cur[LAST_ROW];
      end
      if (r_row != LAST_ROW) begin
         win_s = w_cur[r_row + ROWBITS'(1)];
      end else if (ROW_WRAP) begin
         win_s = w_cur[0];
      end
   end

   // Flag registers are loaded with the value matching the state being entered.
   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel   <= 1'b0;
         r_row   <= '0;
         r_gen   <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (step || run) begin
                  r_state <= SCAN;
                  r_row   <= '0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
               end
            end
            SCAN: begin
               if (nxt_valid) begin
                  if (r_row == LAST_ROW) begin
                     r_state <= SWAP;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_row <= r_row + ROWBITS'(1);
                  end
               end
            end
            SWAP: begin
               r_sel  <= ~r_sel;
               r_gen  <= r_gen + GENBITS'(1);
               r_row  <= '0;
               r_done <= 1'b0;
               if (run) begin
                  r_state <= SCAN;
                  r_valid <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_row   <= '0;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign win_valid = r_valid;
   assign win_row   = r_row;
   assign busy      = r_busy;
   assign gen_done  = r_done;
   assign gen_count = r_gen;

endmodule

`default_nettype wire

// File: tb/tb_gol_gen_buffer.sv
// ============================================================================
// Module   : tb_gol_gen_buffer
// Purpose  : Directed, table-driven bench for gol_gen_buffer (8x8 board).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gol_gen_buffer;

   logic        ph2 = 1'b0;
   logic        reset;
   logic        step, run, load_en, nxt_valid;
   logic [2:0]  load_addr, rd_addr;
   logic [7:0]  load_data, nxt_data;
   logic [7:0]  rd_data, win_n, win_c, win_s;
   logic        win_valid, busy, gen_done, extinct;
   logic [2:0]  win_row;
   logic [15:0] gen_count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef GOL_WRAP_EN
   localparam logic [7:0] EXP_N0 = 8'h81;
   localparam logic [7:0] EXP_S7 = 8'hFF;
`else
   localparam logic [7:0] EXP_N0 = 8'h00;
   localparam logic [7:0] EXP_S7 = 8'h00;
`endif

   always #5 ph2 = ~ph2;

   gol_gen_buffer dut (
      .ph2       (ph2),
      .reset     (reset),
      .step      (step),
      .run       (run),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .win_valid (win_valid),
      .win_row   (win_row),
      .win_n     (win_n),
      .win_c     (win_c),
      .win_s     (win_s),
      .nxt_valid (nxt_valid),
      .nxt_data  (nxt_data),
      .busy      (busy),
      .gen_done  (gen_done),
      .gen_count (gen_count),
      .extinct   (extinct)
   );

   // Board read-back vectors: phase 0 empty, 1 horizontal blinker, 2 vertical.
   typedef struct {
      int         phase;
      logic [2:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   rd_vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ph2);
      #1;
   endtask

   function automatic logic [7:0] life_row(input logic [7:0] n, input logic [7:0] c, input logic [7:0] s);
      logic [9:0] pn, pc, ps;
      logic [7:0] r;
      int cnt;
      pn = {1'b0, n, 1'b0};
      pc = {1'b0, c, 1'b0};
      ps = {1'b0, s, 1'b0};
      r  = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = 0;
         cnt += int'(pn[i]) + int'(pn[i+1]) + int'(pn[i+2]);
         cnt += int'(pc[i]) + int'(pc[i+2]);
         cnt += int'(ps[i]) + int'(ps[i+1]) + int'(ps[i+2]);
         r[i] = (cnt == 3) || (c[i] && (cnt == 2));
      end
      return r;
   endfunction

   task automatic check_phase(input int ph, input string tag);
      foreach (vecs[k]) begin
         if (vecs[k].phase == ph) begin
            rd_addr = vecs[k].addr;
            #1;
            chk($sformatf("%s_row%0d", tag, vecs[k].addr), rd_data, vecs[k].exp);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic load_row(input logic [2:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic load_blinker();
      load_row(3'd3, 8'h08);
      load_row(3'd4, 8'h08);
      load_row(3'd5, 8'h08);
   endtask

   // One stepped generation; returns the cycle (edge 0 = accept) of gen_done.
   task automatic do_gen(input bit toggle, output int done_cyc);
      int         cyc;
      int         bad;
      bit         pv;
      logic [2:0] prow;
      done_cyc = -1;
      bad      = 0;
      pv       = 1'b1;
      prow     = '0;
      step = 1'b1;
      tick();
      step = 1'b0;
      cyc  = 1;
      while (cyc <= 40) begin
         if (gen_done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (!pv && (win_row !== prow)) bad++;
         nxt_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         nxt_data  = life_row(win_n, win_c, win_s);
         pv   = nxt_valid;
         prow = win_row;
         tick();
         cyc++;
      end
      nxt_valid = 1'b0;
      tick();
      chk("win_row_hold", bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         dc;
      int         cyc;
      int         ndone;
      int         done_at[4];
      int         pulses;
      logic [7:0] b1[8];
      logic [7:0] b2[8];

      b1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00};
      b2 = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) begin
         vecs.push_back('{0, 3'(i), 8'h00});
         vecs.push_back('{1, 3'(i), b1[i]});
         vecs.push_back('{2, 3'(i), b2[i]});
      end

      step = 0; run = 0; load_en = 0; load_addr = 0; load_data = 0;
      rd_addr = 0; nxt_valid = 0; nxt_data = 0; reset = 0;
      #2;
      do_reset();

      // Reset state
      check_phase(0, "rst");
      chk("rst_extinct", extinct, 1);
      chk("rst_gen_count", gen_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_win_valid", win_valid, 0);
      chk("rst_gen_done", gen_done, 0);
      chk("rst_win_ncs", {win_n, win_c, win_s}, 0);

      // Blinker, nxt_valid held high
      load_blinker();
      rd_addr = 3'd4;
      #1;
      chk("load_raw", rd_data, 8'h08);
      chk("load_extinct", extinct, 0);
      do_gen(1'b0, dc);
      chk("gen_done_cycle_full", dc, 9);
      check_phase(1, "blink1");
      chk("blink1_gen_count", gen_count, 1);
      chk("blink1_busy", busy, 0);

      // Same generation with nxt_valid toggling
      do_reset();
      load_blinker();
      do_gen(1'b1, dc);
      chk("gen_done_cycle_toggle", dc, 17);
      check_phase(1, "blink2");
      chk("blink2_gen_count", gen_count, 1);

      // Row-edge neighbours, with a load accepted in the same cycle as step
      load_row(3'd0, 8'hFF);
      load_en = 1'b1; load_addr = 3'd7; load_data = 8'h81; step = 1'b1; rd_addr = 3'd7;
      tick();
      load_en = 1'b0; step = 1'b0;
      chk("edge_win_valid", win_valid, 1);
      chk("edge_win_row0", win_row, 0);
      chk("edge_win_c0", win_c, 8'hFF);
      chk("edge_win_n0", win_n, EXP_N0);
      chk("edge_same_cycle_load", rd_data, 8'h81);
      cyc = 0;
      while (cyc < 20 && !(win_valid === 1'b1 && win_row === 3'd7)) begin
         nxt_valid = 1'b1;
         nxt_data  = life_row(win_n, win_c, win_s);
         tick();
         cyc++;
      end
      chk("edge_reach_row7", win_row, 7);
      chk("edge_win_c7", win_c, 8'h81);
      chk("edge_win_s7", win_s, EXP_S7);
      cyc = 0;
      while (cyc < 20 && gen_done !== 1'b1) begin
         nxt_valid = 1'b1;
         nxt_data  = life_row(win_n, win_c, win_s);
         tick();
         cyc++;
      end
      nxt_valid = 1'b0;
      tick();
      chk("edge_gen_count", gen_count, 2);

      // Run mode for three generations, dropped during the fourth
      do_reset();
      load_blinker();
      run   = 1'b1;
      tick();
      cyc   = 1;
      ndone = 0;
      done_at = '{-1, -1, -1, -1};
      while (cyc <= 60) begin
         if (gen_done === 1'b1 && ndone < 4) begin
            done_at[ndone] = cyc;
            ndone++;
         end
         if (busy === 1'b1) begin
            load_en = 1'b1; load_addr = 3'd2; load_data = 8'hFF; step = 1'b1;
         end else begin
            load_en = 1'b0; step = 1'b0;
            break;
         end
         if (cyc == 31) run = 1'b0;
         nxt_valid = 1'b1;
         nxt_data  = life_row(win_n, win_c, win_s);
         tick();
         cyc++;
      end
      load_en = 1'b0; step = 1'b0; nxt_valid = 1'b0; run = 1'b0;
      for (int g = 0; g < 4; g++) chk($sformatf("run_done_cycle%0d", g), done_at[g], 9 * (g + 1));
      chk("run_gen_count", gen_count, 4);
      chk("run_idle_busy", busy, 0);
      check_phase(2, "run");

      // Reset asserted mid-generation at win_row 5
      step = 1'b1;
      tick();
      step = 1'b0;
      cyc  = 0;
      while (cyc < 20 && win_row !== 3'd5) begin
         nxt_valid = 1'b1;
         nxt_data  = life_row(win_n, win_c, win_s);
         tick();
         cyc++;
      end
      chk("abort_reach_row5", win_row, 5);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_win_valid", win_valid, 0);
      chk("abort_gen_count", gen_count, 0);
      chk("abort_extinct", extinct, 1);
      chk("abort_win_row", win_row, 0);
      #1 reset = 1'b0;
      check_phase(0, "abort");
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         nxt_valid = 1'b1;
         nxt_data  = 8'hA5;
         tick();
         if (gen_done !== 1'b0 || busy !== 1'b0) pulses++;
      end
      nxt_valid = 1'b0;
      chk("abort_no_gen_done", pulses, 0);
      chk("abort_still_empty", extinct, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gol_gen_buffer.md
# gol_gen_buffer

Double-buffered Game-of-Life board store, successor to the single-bank row register file. Holds the current and next generation in two banks of ROWS × WIDTH cells, scans the current bank row by row, and presents each row with its north and south neighbours to the downstream cell-update logic. It accepts the computed next row back through a valid handshake and swaps banks at generation end. Sits between the host load/display path and the per-row GoL compute block.

## Interface
- WIDTH, 8, cells per row
- ROWS, 8, rows per board (≥ 3; need not be a power of 2)
- ROWBITS, $clog2(ROWS), row address width
- GENBITS, 16, generation counter width
- ph2  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- step  in  1  start one generation (accepted in IDLE only)
- run  in  1  continuous mode; while high, SWAP returns directly to SCAN
- load_en  in  1  host write to current bank (accepted in IDLE only)
- load_addr  in  ROWBITS  host write row
- load_data  in  WIDTH  host write data
- rd_addr  in  ROWBITS  display read row
- rd_data  out  WIDTH  current bank[rd_addr], combinational
- win_valid  out  1  window valid (state == SCAN)
- win_row  out  ROWBITS  row index being computed
- win_n, win_c, win_s  out  WIDTH each  rows win_row−1, win_row, win_row+1 of the current bank
- nxt_valid  in  1  downstream returns next-generation row for win_row
- nxt_data  in  WIDTH  next-generation row data
- busy  out  1  state != IDLE
- gen_done  out  1  high for exactly the SWAP cycle
- gen_count  out  GENBITS  completed generations, wraps modulo 2^GENBITS
- extinct  out  1  all rows of current bank zero, combinational

## Operation
- States: IDLE, SCAN, SWAP.
- IDLE: step → SCAN with win_row = 0; run alone in IDLE also → SCAN. load_en writes current bank[load_addr] = load_data. Out-of-range load_addr (≥ ROWS) is ignored.
- SCAN: a handshake completes when nxt_valid is high. On completion, next bank[win_row] = nxt_data. If win_row == ROWS−1, go to SWAP; otherwise increment win_row. With nxt_valid low, the state holds and the window is stable.
- SWAP: bank select toggles, gen_count increments, win_row clears to 0. The next state is SCAN if run is high, otherwise IDLE.
- step, load_en in SCAN/SWAP are ignored (no queuing). nxt_valid outside SCAN is ignored.
- Deasserting run mid-generation finishes that generation, then returns to IDLE.
- step and load_en in the same IDLE cycle: the load is performed and the step is accepted. The first SCAN cycle sees the loaded data.
- Reset values: state IDLE, both banks all-zero, bank select 0, win_row 0, gen_count 0, busy 0, win_valid 0, gen_done 0. With zero banks, extinct = 1 and win_n/c/s = 0.
- Reset asserted mid-generation aborts immediately. No partial swap survives.

## Timing
- rd_data, win_n/c/s and extinct are combinational from the current bank. They update the cycle after a write or swap edge.
- With nxt_valid held high, step accepted at edge 0 gives SCAN for ROWS cycles, then SWAP for 1 cycle. gen_done is high in cycle ROWS+1.
- A generation costs ROWS+1 cycles back-to-back in run mode.
- Cycle after gen_done: rd_data shows the new generation and gen_count shows the incremented value.
- Load write takes effect at the accepting edge, with zero-cycle read-after-write on the next cycle.

## Configuration
- GOL_WRAP_EN defined: toroidal rows. win_n for row 0 is row ROWS−1, and win_s for row ROWS−1 is row 0, using explicit compare (not modulo-2^ROWBITS).
- GOL_WRAP_EN undefined: rows outside the board read as zero. win_n = 0 at row 0, win_s = 0 at row ROWS−1.
- Column wrap is always the downstream block's responsibility.

## Structure
- Shared package gol_pkg holds the state typedef (IDLE/SCAN/SWAP) and the default WIDTH/ROWS constants.
- Sub-module gol_row_bank: ROWS × WIDTH storage with one synchronous write port, async reset to zero, and combinational read ports. It is instantiated twice.
- Top level holds the FSM, counters, bank select and window mux.

## Test plan
- Reset, then read all rows → rd_data = 0 everywhere, extinct = 1, gen_count = 0, busy = 0.
- Load blinker (rows 3,4,5 = 8'h08), step, with a reference model on nxt_* holding nxt_valid = 1 → gen_done in cycle 9. Then row 4 = 8'h1C, rows 3,5 = 0, gen_count = 1.
- Same generation with nxt_valid toggling every other cycle → identical result; win_row holds while nxt_valid is low; gen_done in cycle 17.
- Row 0 = 8'hFF, row 7 = 8'h81, step → at win_row = 0, win_n = 8'h81 with GOL_WRAP_EN and 8'h00 without. At win_row = 7, win_s = 8'hFF with the macro and 0 without.
- run held for 3 generations, then dropped mid-4th → gen_done every 9 cycles, and IDLE after gen_count = 4. load_en/step during busy leave banks unchanged.
- Assert reset at win_row = 5 → immediate IDLE, banks zero, gen_count = 0, gen_done never pulses.
